pic: RTL and testbench
======================

PIC -- requirements
Module: pic

Interface
REQ-001 Parameter VECTOR_BASE, 8'h08, interrupt vector number for line 0; line n yields VECTOR_BASE+n.
REQ-002 Parameter PORT_BASE, 16'h0020, command port address; the mask port is PORT_BASE+1.
REQ-003 clock  input  1  single clock domain, CPU clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_in  input  8  interrupt request lines, level from sources (bit 0 = timer, bit 1 = keyboard).
REQ-006 irq_signal  output  1  interrupt request to CPU.
REQ-007 irq_id  output  8  vector number presented with irq_signal.
REQ-008 irq_ack  input  1  one-cycle CPU acknowledge of the presented vector.
REQ-009 port_address  input  16  CPU I/O address.
REQ-010 port_write  input  1  one-cycle I/O write strobe.
REQ-011 port_read  input  1  one-cycle I/O read strobe.
REQ-012 port_out  input  8  write data from CPU.
REQ-013 port_in  output  8  read data to CPU.
REQ-014 port_ready  output  1  one-cycle completion pulse for an addressed access.

Function
REQ-015 Each irq_in bit SHALL be registered; a 0->1 transition between consecutive samples SHALL set the matching IRR bit on the next edge; levels alone SHALL NOT set IRR.
REQ-016 Edges on several lines in one cycle SHALL all be latched in IRR.
REQ-017 pending = IRR & ~IMR; priority SHALL be fixed, lowest index highest.
REQ-018 FSM states: IDLE, REQ, SERVICE.
REQ-019 IDLE: if pending != 0, latch highest-priority index into cur, drive irq_id = VECTOR_BASE+cur (8-bit wrap), assert irq_signal, go REQ; irq_signal rises one cycle after the IRR bit is set.
REQ-020 REQ: irq_signal and irq_id SHALL hold stable until irq_ack or withdrawal.
REQ-021 REQ with irq_ack=1: clear IRR[cur], set ISR[cur], deassert irq_signal next cycle, go SERVICE.
REQ-022 REQ with IMR[cur] set (mask written) and irq_ack=0: deassert irq_signal, go IDLE, IRR[cur] retained.
REQ-023 A new rising edge on line cur in the same cycle as its irq_ack SHALL leave IRR[cur] set (new request wins).
REQ-024 irq_ack outside REQ SHALL be ignored.
REQ-025 SERVICE: no new request presented (no nesting); IRR keeps latching edges.
REQ-026 Write of 8'h20 (non-specific EOI) to PORT_BASE SHALL clear ISR and return the FSM to IDLE next cycle; other values to PORT_BASE SHALL be ignored; EOI outside SERVICE SHALL be ignored.
REQ-027 Write to PORT_BASE+1 SHALL load IMR from port_out on the next edge.
REQ-028 Read of PORT_BASE SHALL return ISR, PORT_BASE+1 SHALL return IMR, registered, valid the cycle after port_read.
REQ-029 port_ready SHALL pulse high exactly one cycle after a read or write to PORT_BASE or PORT_BASE+1; other addresses produce no pulse and leave port_in unchanged.

Reset
REQ-030 On reset: IRR=0, ISR=0, IMR=8'hFF, edge sample registers=0, FSM=IDLE, irq_signal=0, irq_id=8'h00, port_in=8'h00, port_ready=0.
REQ-031 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the interrupt; irq_signal=0 on the cycle after reset is sampled.
REQ-032 A line held high through reset release SHALL NOT generate a request until it falls and rises again.

Verification
REQ-033 Reset, write 8'hFC to 0x21, pulse irq_in[1] -> irq_signal=1, irq_id=8'h09 next cycle; irq_ack -> irq_signal=0, read 0x20 returns 8'h02.
REQ-034 IMR=8'h00, rise irq_in[0] and irq_in[3] same cycle -> irq_id=8'h08 first; ack, write 8'h20 to 0x20 -> irq_id=8'h0B presented.
REQ-035 IMR=8'hFF, pulse irq_in[2] -> no irq_signal; write 8'hFB to 0x21 -> irq_signal=1, irq_id=8'h0A.
REQ-036 IMR=8'h00, irq_in[4] request in REQ, write 8'hFF to 0x21 -> irq_signal drops, FSM IDLE; write 8'h00 -> irq_id=8'h0C re-presented.
REQ-037 Assert reset while in SERVICE with irq_in[0] held high -> irq_signal=0, read 0x21 returns 8'hFF, no request until irq_in[0] toggles.
REQ-038 Write 8'h55 to 0x40 and read 0x40 -> port_ready stays 0, IMR unchanged.

Source files
------------

// File: rtl/pic.sv
// rtl/pic.sv - Single-level programmable interrupt controller
// Edge-latched requests, fixed priority (line 0 highest), one interrupt in service at a time.
module pic #(
  parameter logic [7:0]  VECTOR_BASE = 8'h08,
  parameter logic [15:0] PORT_BASE   = 16'h0020
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq_in,
  output logic        irq_signal,
  output logic [7:0]  irq_id,
  input  logic        irq_ack,
  input  logic [15:0] port_address,
  input  logic        port_write,
  input  logic        port_read,
  input  logic [7:0]  port_out,
  output logic [7:0]  port_in,
  output logic        port_ready
);

  localparam logic [15:0] MASK_PORT = PORT_BASE + 16'd1;
  localparam logic [7:0]  EOI_CMD   = 8'h20;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] imr;
  logic [7:0] irq_prev;
  logic       primed;
  logic [2:0] cur;

  logic [7:0] rise;
  logic [7:0] pending;
  logic [2:0] top_idx;
  logic       cmd_hit;
  logic       mask_hit;
  logic       eoi;

  // primed stays low for the first sample after reset, so a line held high
  // through reset release must fall and rise again before it counts.
  assign rise     = primed ? (irq_in & ~irq_prev) : 8'h00;
  assign pending  = irr & ~imr;
  assign cmd_hit  = (port_address == PORT_BASE);
  assign mask_hit = (port_address == MASK_PORT);
  assign eoi      = port_write && cmd_hit && (port_out == EOI_CMD);

  always_comb begin
    top_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) top_idx = 3'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      irr        <= 8'h00;
      isr        <= 8'h00;
      imr        <= 8'hFF;
      irq_prev   <= 8'h00;
      primed     <= 1'b0;
      cur        <= 3'd0;
      irq_signal <= 1'b0;
      irq_id     <= 8'h00;
      port_in    <= 8'h00;
      port_ready <= 1'b0;
    end else begin
      irq_prev   <= irq_in;
      primed     <= 1'b1;
      irr        <= irr | rise;
      port_ready <= (port_write || port_read) && (cmd_hit || mask_hit);

      if (port_write && mask_hit) imr <= port_out;

      if (port_read && cmd_hit) port_in <= isr;
      else if (port_read && mask_hit) port_in <= imr;

      case (state)
        IDLE: begin
          if (|pending) begin
            cur        <= top_idx;
            irq_id     <= VECTOR_BASE + {5'b00000, top_idx};
            irq_signal <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            // A fresh edge on the acknowledged line re-arms it immediately.
            irr        <= (irr & ~(8'h01 << cur)) | rise;
            isr[cur]   <= 1'b1;
            irq_signal <= 1'b0;
            state      <= SERVICE;
          end else if (imr[cur]) begin
            irq_signal <= 1'b0;
            state      <= IDLE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            isr   <= 8'h00;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic.sv
// tb/tb_pic.sv - Self-checking bench for pic
// Directed scenarios followed by randomized traffic, all checked against a behavioural model.
module tb_pic;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        irq_signal;
  logic [7:0]  irq_id;
  logic        irq_ack;
  logic [15:0] port_address;
  logic        port_write;
  logic        port_read;
  logic [7:0]  port_out;
  logic [7:0]  port_in;
  logic        port_ready;

  int checks = 0;
  int errors = 0;

  pic #(.VECTOR_BASE(8'h08), .PORT_BASE(16'h0020)) dut (
    .clock(clock), .reset(reset), .irq_in(irq_in), .irq_signal(irq_signal),
    .irq_id(irq_id), .irq_ack(irq_ack), .port_address(port_address),
    .port_write(port_write), .port_read(port_read), .port_out(port_out),
    .port_in(port_in), .port_ready(port_ready)
  );

  always #5 clock = ~clock;

  // Reference model: phase 0 = waiting, 1 = presenting, 2 = in service.
  bit [7:0] m_irr, m_isr, m_imr, m_prev, m_id, m_pin;
  bit       m_primed, m_sig, m_rdy;
  int       m_phase, m_cur;
  bit [7:0] lvl;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit [7:0] irq, input bit ack,
                            input bit [15:0] addr, input bit wr, input bit rd,
                            input bit [7:0] dat);
    bit [7:0] rise, n_irr, n_isr, n_imr, open_req;
    int first;
    if (rst) begin
      m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_prev = 0; m_primed = 0;
      m_phase = 0; m_cur = 0; m_sig = 0; m_id = 0; m_pin = 0; m_rdy = 0;
    end else begin
      rise = 0;
      for (int n = 0; n < 8; n++)
        if (m_primed && irq[n] && !m_prev[n]) rise[n] = 1'b1;
      n_irr = m_irr | rise;
      n_isr = m_isr;
      n_imr = m_imr;
      open_req = m_irr & ~m_imr;
      case (m_phase)
        0: begin
          first = -1;
          for (int n = 7; n >= 0; n--) if (open_req[n]) first = n;
          if (first >= 0) begin
            m_cur = first; m_sig = 1; m_id = 8'(8'h08 + first); m_phase = 1;
          end
        end
        1: begin
          if (ack) begin
            n_irr[m_cur] = rise[m_cur]; n_isr[m_cur] = 1'b1; m_sig = 0; m_phase = 2;
          end else if (m_imr[m_cur]) begin
            m_sig = 0; m_phase = 0;
          end
        end
        default: begin
          if (wr && addr == 16'h0020 && dat == 8'h20) begin
            n_isr = 0; m_phase = 0;
          end
        end
      endcase
      if (wr && addr == 16'h0021) n_imr = dat;
      m_rdy = (wr || rd) && (addr == 16'h0020 || addr == 16'h0021);
      if (rd && addr == 16'h0020) m_pin = m_isr;
      else if (rd && addr == 16'h0021) m_pin = m_imr;
      m_irr = n_irr; m_isr = n_isr; m_imr = n_imr;
      m_prev = irq; m_primed = 1;
    end
  endtask

  task automatic tick(input bit rst, input bit ack, input bit [15:0] addr,
                      input bit wr, input bit rd, input bit [7:0] dat);
    reset = rst; irq_in = lvl; irq_ack = ack; port_address = addr;
    port_write = wr; port_read = rd; port_out = dat;
    @(posedge clock);
    model_step(rst, lvl, ack, addr, wr, rd, dat);
    #1;
    chk("irq_signal", {7'b0, irq_signal}, {7'b0, m_sig});
    chk("irq_id", irq_id, m_id);
    chk("port_ready", {7'b0, port_ready}, {7'b0, m_rdy});
    chk("port_in", port_in, m_pin);
  endtask

  task automatic idle();                              tick(0, 0, 16'h0000, 0, 0, 8'h00); endtask
  task automatic wr_port(input bit [15:0] a, input bit [7:0] d); tick(0, 0, a, 1, 0, d); endtask
  task automatic rd_port(input bit [15:0] a);         tick(0, 0, a, 0, 1, 8'h00); endtask
  task automatic ack();                               tick(0, 1, 16'h0000, 0, 0, 8'h00); endtask

  initial begin
    bit [31:0] r;
    bit        a, rs;
    int        sel;
    lvl = 8'h00;

    // Reset state
    tick(1, 0, 16'h0000, 0, 0, 8'h00);
    tick(1, 0, 16'h0000, 0, 0, 8'h00);
    chk("rst_sig", {7'b0, irq_signal}, 8'h00);
    chk("rst_id", irq_id, 8'h00);
    chk("rst_pin", port_in, 8'h00);
    chk("rst_rdy", {7'b0, port_ready}, 8'h00);
    idle();

    // Keyboard line unmasked, presented, acknowledged, ISR read back
    wr_port(16'h0021, 8'hFC);
    chk("imr_wr_rdy", {7'b0, port_ready}, 8'h01);
    lvl = 8'h02; idle();
    chk("irr_set_no_sig_yet", {7'b0, irq_signal}, 8'h00);
    lvl = 8'h00; idle();
    chk("kbd_sig", {7'b0, irq_signal}, 8'h01);
    chk("kbd_id", irq_id, 8'h09);
    idle();
    chk("kbd_hold", irq_id, 8'h09);
    ack();
    chk("kbd_ack_drop", {7'b0, irq_signal}, 8'h00);
    rd_port(16'h0020);
    chk("kbd_isr", port_in, 8'h02);
    wr_port(16'h0020, 8'h20);

    // Simultaneous edges: lowest index first, next after EOI
    wr_port(16'h0021, 8'h00);
    lvl = 8'h09; idle();
    lvl = 8'h00; idle();
    chk("dual_first", irq_id, 8'h08);
    ack();
    wr_port(16'h0020, 8'h13);
    chk("non_eoi_ignored", {7'b0, irq_signal}, 8'h00);
    wr_port(16'h0020, 8'h20);
    idle();
    chk("dual_second_sig", {7'b0, irq_signal}, 8'h01);
    chk("dual_second", irq_id, 8'h0B);
    ack(); wr_port(16'h0020, 8'h20);

    // Masked request becomes visible when unmasked
    wr_port(16'h0021, 8'hFF);
    lvl = 8'h04; idle();
    lvl = 8'h00; idle(); idle();
    chk("masked_quiet", {7'b0, irq_signal}, 8'h00);
    wr_port(16'h0021, 8'hFB);
    idle();
    chk("unmask_sig", {7'b0, irq_signal}, 8'h01);
    chk("unmask_id", irq_id, 8'h0A);
    ack(); wr_port(16'h0020, 8'h20);

    // Withdrawal on masking during presentation, re-presented after unmask
    wr_port(16'h0021, 8'h00);
    lvl = 8'h10; idle();
    lvl = 8'h00; idle();
    chk("w_id", irq_id, 8'h0C);
    wr_port(16'h0021, 8'hFF);
    idle();
    chk("w_drop", {7'b0, irq_signal}, 8'h00);
    ack();
    chk("stray_ack", {7'b0, irq_signal}, 8'h00);
    wr_port(16'h0021, 8'h00);
    idle();
    chk("w_again_sig", {7'b0, irq_signal}, 8'h01);
    chk("w_again_id", irq_id, 8'h0C);
    ack(); wr_port(16'h0020, 8'h20);

    // Reset during service with timer line held high
    lvl = 8'h01; idle();
    idle();
    ack();
    tick(1, 0, 16'h0000, 0, 0, 8'h00);
    chk("svc_rst_sig", {7'b0, irq_signal}, 8'h00);
    wr_port(16'h0021, 8'h00);
    idle(); idle(); idle();
    chk("held_no_req", {7'b0, irq_signal}, 8'h00);
    rd_port(16'h0020);
    chk("held_isr", port_in, 8'h00);
    lvl = 8'h00; idle();
    lvl = 8'h01; idle();
    idle();
    chk("retoggle_id", irq_id, 8'h08);
    ack(); wr_port(16'h0020, 8'h20);
    tick(1, 0, 16'h0000, 0, 0, 8'h00);
    rd_port(16'h0021);
    chk("rst_imr", port_in, 8'hFF);

    // Unmapped address
    wr_port(16'h0040, 8'h55);
    chk("foreign_wr_rdy", {7'b0, port_ready}, 8'h00);
    rd_port(16'h0040);
    chk("foreign_rd_rdy", {7'b0, port_ready}, 8'h00);
    chk("foreign_rd_pin", port_in, 8'hFF);
    rd_port(16'h0021);
    chk("foreign_imr", port_in, 8'hFF);

    // Randomized traffic
    lvl = 8'h00;
    for (int k = 0; k < 600; k++) begin
      r = $urandom;
      lvl = lvl ^ (r[7:0] & r[15:8] & r[23:16]);
      rs = ($urandom_range(0, 149) == 0);
      a = m_sig ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0: tick(rs, a, 16'h0021, 1, 0, 8'($urandom & $urandom));
        1: tick(rs, a, 16'h0020, 1, 0, 8'h20);
        2: tick(rs, a, 16'h0020, 0, 1, 8'h00);
        3: tick(rs, a, 16'h0021, 0, 1, 8'h00);
        4: tick(rs, a, 16'h0020, 1, 0, 8'($urandom));
        5: tick(rs, a, 16'h0040, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
        default: tick(rs, a, 16'($urandom), 0, 0, 8'h00);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
